// File: rtl/bird_cpu_p.sv
// rtl/bird_cpu_p.sv - parametrised multi-cycle bird register CPU with ready/request memory port
//
// Eight DATA_W registers (R7 = SP), Z/C flags, one shared instruction/data
// memory port with wait states. Instructions are the low 16 bits of a word.
//
// Opcode map (ir[15:12]):
//   0 NOP   1 LDI   2 LD    3 ST    4 JZ    5 JMP   6 JC    7 ALU
//   8 PUSH  9 POP   A CALL  B RET   C/D/E NOP   F HALT
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   mem_rdata  in   read data, valid in the cycle mem_rdy=1
//   mem_rdy    in   current access completes this cycle
//   mem_addr   out  access address
//   mem_wdata  out  write data
//   mem_req    out  access request
//   mem_we     out  write strobe, qualified by mem_req
//   halted     out  core has executed HALT

module bird_cpu_p #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [DATA_W-1:0] RESET_SP = DATA_W'({ADDR_W{1'b1}})
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rdy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic              halted
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_LDI    = 4'd2;
   localparam logic [3:0] S_LD     = 4'd3;
   localparam logic [3:0] S_ST     = 4'd4;
   localparam logic [3:0] S_JMP    = 4'd5;
   localparam logic [3:0] S_PUSH1  = 4'd6;
   localparam logic [3:0] S_PUSH2  = 4'd7;
   localparam logic [3:0] S_POP    = 4'd8;
   localparam logic [3:0] S_CALL1  = 4'd9;
   localparam logic [3:0] S_CALL2  = 4'd10;
   localparam logic [3:0] S_CALL3  = 4'd11;
   localparam logic [3:0] S_RET    = 4'd12;
   localparam logic [3:0] S_HALT   = 4'd13;

   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_LD   = 4'h2;
   localparam logic [3:0] OP_ST   = 4'h3;
   localparam logic [3:0] OP_JZ   = 4'h4;
   localparam logic [3:0] OP_JMP  = 4'h5;
   localparam logic [3:0] OP_JC   = 4'h6;
   localparam logic [3:0] OP_ALU  = 4'h7;
   localparam logic [3:0] OP_PUSH = 4'h8;
   localparam logic [3:0] OP_POP  = 4'h9;
   localparam logic [3:0] OP_CALL = 4'hA;
   localparam logic [3:0] OP_RET  = 4'hB;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);
   localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

   logic [3:0]        state;
   logic [15:0]       ir;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] tgt;
   logic [DATA_W-1:0] regs [0:7];
   logic              z;
   logic              c;

   logic [3:0] op;
   logic [2:0] f;
   logic [2:0] a;
   logic [2:0] b;
   logic [2:0] d;

   assign op = ir[15:12];
   assign f  = ir[11:9];
   assign a  = ir[8:6];
   assign b  = ir[5:3];
   assign d  = ir[2:0];

   logic [DATA_W-1:0] ra_val;
   logic [DATA_W-1:0] rb_val;
   logic [DATA_W-1:0] sp;

   assign ra_val = regs[a];
   assign rb_val = regs[b];
   assign sp     = regs[7];

   // ALU: result and next carry; carry defaults to "unchanged"
   logic [DATA_W-1:0] alu_res;
   logic              alu_c;

   always_comb begin
      alu_res = '0;
      alu_c   = c;
      case (f)
         3'd0: {alu_c, alu_res} = {1'b0, ra_val} + {1'b0, rb_val};
         3'd1: begin
            alu_res = ra_val - rb_val;
            alu_c   = (ra_val < rb_val);
         end
         3'd2: alu_res = ra_val & rb_val;
         3'd3: alu_res = ra_val | rb_val;
         3'd4: alu_res = ra_val ^ rb_val;
         3'd5: begin
            alu_res = {ra_val[DATA_W-2:0], 1'b0};
            alu_c   = ra_val[DATA_W-1];
         end
         3'd6: begin
            alu_res = {1'b0, ra_val[DATA_W-1:1]};
            alu_c   = ra_val[0];
         end
         default: begin
            // unary group: the a field selects the operation, operand is Rb
            case (a)
               3'd0: alu_res = ~rb_val;
               3'd1: alu_res = rb_val;
               3'd2: {alu_c, alu_res} = {1'b0, rb_val} + {1'b0, DATA_ONE};
               3'd3: begin
                  alu_res = rb_val - DATA_ONE;
                  alu_c   = (rb_val == '0);
               end
               default: alu_res = '0;
            endcase
         end
      endcase
   end

   // Memory port is a pure function of state and registers, so it stays
   // stable across wait states without extra holding registers.
   logic mem_state;

   always_comb begin
      mem_state = 1'b0;
      mem_addr  = pc;
      mem_wdata = '0;
      mem_we    = 1'b0;
      case (state)
         S_FETCH, S_LDI, S_JMP, S_CALL1: begin
            mem_state = 1'b1;
            mem_addr  = pc;
         end
         S_LD: begin
            mem_state = 1'b1;
            mem_addr  = ADDR_W'(rb_val);
         end
         S_ST: begin
            mem_state = 1'b1;
            mem_addr  = ADDR_W'(rb_val);
            mem_wdata = ra_val;
            mem_we    = 1'b1;
         end
         S_PUSH2: begin
            mem_state = 1'b1;
            mem_addr  = ADDR_W'(sp);
            mem_wdata = ra_val;
            mem_we    = 1'b1;
         end
         S_CALL3: begin
            mem_state = 1'b1;
            mem_addr  = ADDR_W'(sp);
            mem_wdata = DATA_W'(pc);
            mem_we    = 1'b1;
         end
         S_POP, S_RET: begin
            mem_state = 1'b1;
            mem_addr  = ADDR_W'(sp);
         end
         default: begin
            mem_state = 1'b0;
         end
      endcase
   end

   // Gating with rst_n drops the request the moment reset is asserted,
   // even in the middle of a stalled access.
   assign mem_req = mem_state & rst_n;
   assign halted  = (state == S_HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_FETCH;
         pc    <= RESET_PC;
         ir    <= '0;
         tgt   <= '0;
         z     <= 1'b0;
         c     <= 1'b0;
         for (int i = 0; i < 7; i++) begin
            regs[i] <= '0;
         end
         regs[7] <= RESET_SP;
      end else begin
         case (state)
            S_FETCH: begin
               if (mem_rdy) begin
                  ir    <= mem_rdata[15:0];
                  pc    <= pc + PC_ONE;
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               case (op)
                  OP_ALU: begin
                     regs[d] <= alu_res;
                     z       <= (alu_res == '0);
                     c       <= alu_c;
                     state   <= S_FETCH;
                  end
                  OP_JZ, OP_JC: begin
                     // not taken: step over the operand word
                     if ((op == OP_JZ) ? z : c) begin
                        state <= S_JMP;
                     end else begin
                        pc    <= pc + PC_ONE;
                        state <= S_FETCH;
                     end
                  end
                  OP_JMP:  state <= S_JMP;
                  OP_LDI:  state <= S_LDI;
                  OP_LD:   state <= S_LD;
                  OP_ST:   state <= S_ST;
                  OP_PUSH: state <= S_PUSH1;
                  OP_POP:  state <= S_POP;
                  OP_CALL: state <= S_CALL1;
                  OP_RET:  state <= S_RET;
                  OP_HALT: state <= S_HALT;
                  default: state <= S_FETCH;
               endcase
            end
            S_LDI: begin
               if (mem_rdy) begin
                  regs[d] <= mem_rdata;
                  pc      <= pc + PC_ONE;
                  state   <= S_FETCH;
               end
            end
            S_LD: begin
               if (mem_rdy) begin
                  regs[d] <= mem_rdata;
                  state   <= S_FETCH;
               end
            end
            S_ST: begin
               if (mem_rdy) begin
                  state <= S_FETCH;
               end
            end
            S_JMP: begin
               if (mem_rdy) begin
                  pc    <= ADDR_W'(mem_rdata);
                  state <= S_FETCH;
               end
            end
            S_PUSH1: begin
               regs[7] <= sp - DATA_ONE;
               state   <= S_PUSH2;
            end
            S_PUSH2: begin
               if (mem_rdy) begin
                  state <= S_FETCH;
               end
            end
            S_POP: begin
               if (mem_rdy) begin
                  // second assignment wins when d selects R7
                  regs[7] <= sp + DATA_ONE;
                  regs[d] <= mem_rdata;
                  state   <= S_FETCH;
               end
            end
            S_CALL1: begin
               if (mem_rdy) begin
                  tgt   <= ADDR_W'(mem_rdata);
                  pc    <= pc + PC_ONE;
                  state <= S_CALL2;
               end
            end
            S_CALL2: begin
               regs[7] <= sp - DATA_ONE;
               state   <= S_CALL3;
            end
            S_CALL3: begin
               if (mem_rdy) begin
                  pc    <= tgt;
                  state <= S_FETCH;
               end
            end
            S_RET: begin
               if (mem_rdy) begin
                  pc      <= ADDR_W'(mem_rdata);
                  regs[7] <= sp + DATA_ONE;
                  state   <= S_FETCH;
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bird_cpu_p.sv
// tb/tb_bird_cpu_p.sv - self-checking bench for bird_cpu_p

module tb_bird_cpu_p;

   logic        clk;
   logic        rst_n;
   logic [15:0] mem_rdata;
   logic        mem_rdy;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_req;
   logic        mem_we;
   logic        halted;

   logic [15:0] mem [0:4095];
   int          n_vec;
   int          n_err;
   int          wr_count;

   bird_cpu_p dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_rdata (mem_rdata),
      .mem_rdy   (mem_rdy),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .halted    (halted)
   );

   assign mem_rdata = mem[mem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f;
      logic [2:0]  sel;
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] res;
      logic        cf;
      logic        zf;
   } alu_vec_t;

   alu_vec_t vt [14];

   function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] f,
                                       input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] d);
      return {op, f, a, b, d};
   endfunction

   // Reference ALU from the instruction-set rules, in plain arithmetic
   task automatic model(input logic [2:0] f, input logic [2:0] sel,
                        input logic [15:0] x, input logic [15:0] y, input logic cin,
                        output logic [15:0] r, output logic co, output logic zo);
      int unsigned s;
      int unsigned ux;
      int unsigned uy;
      ux = x;
      uy = y;
      co = cin;
      r  = 16'h0;
      case (f)
         3'd0: begin s = ux + uy; r = 16'(s % 65536); co = (s > 65535); end
         3'd1: begin s = (ux + 65536 - uy) % 65536; r = 16'(s); co = (ux < uy); end
         3'd2: r = x & y;
         3'd3: r = x | y;
         3'd4: r = x ^ y;
         3'd5: begin r = 16'((ux * 2) % 65536); co = (ux >= 32768); end
         3'd6: begin r = 16'(ux / 2); co = (ux % 2 == 1); end
         default: begin
            case (sel)
               3'd0: r = 16'(65535 - uy);
               3'd1: r = y;
               3'd2: begin r = 16'((uy + 1) % 65536); co = (uy == 65535); end
               3'd3: begin r = 16'((uy + 65535) % 65536); co = (uy == 0); end
               default: r = 16'h0;
            endcase
         end
      endcase
      zo = (r == 16'h0);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock; memory writes are committed on the edge they complete
   task automatic cycle();
      logic        w;
      logic [11:0] wa;
      logic [15:0] wd;
      w  = rst_n && mem_req && mem_rdy && mem_we;
      wa = mem_addr;
      wd = mem_wdata;
      @(posedge clk);
      if (w) begin
         mem[wa] = wd;
         wr_count++;
      end
      #1;
   endtask

   task automatic begin_prog();
      rst_n   = 1'b0;
      mem_rdy = 1'b1;
      #1;
      for (int i = 0; i < 4096; i++) mem[i] = 16'hF000;
      wr_count = 0;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_halted", halted, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      rst_n = 1'b1;
      #1;
      chk("req_after_release", mem_req, 1);
   endtask

   task automatic run_until_halt(input int budget);
      int n;
      n = 0;
      mem_rdy = 1'b1;
      while (!halted && n < budget) begin
         cycle();
         n++;
      end
      chk("halt_reached", halted, 1);
   endtask

   task automatic run_alu(input logic [2:0] f, input logic [2:0] sel,
                          input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] er, input logic ec, input logic ez);
      begin_prog();
      mem[0] = enc(4'h1, 3'd0, 3'd0, 3'd0, 3'd1);
      mem[1] = x;
      mem[2] = enc(4'h1, 3'd0, 3'd0, 3'd0, 3'd2);
      mem[3] = y;
      mem[4] = enc(4'h7, f, (f == 3'd7) ? sel : 3'd1, 3'd2, 3'd3);
      release_reset();
      run_until_halt(40);
      chk($sformatf("alu_res f%0d s%0d", f, sel), dut.regs[3], er);
      chk($sformatf("alu_c f%0d s%0d", f, sel), dut.c, ec);
      chk($sformatf("alu_z f%0d s%0d", f, sel), dut.z, ez);
   endtask

   initial begin
      logic [2:0]  rf;
      logic [2:0]  rs;
      logic [15:0] rx;
      logic [15:0] ry;
      logic [15:0] mr;
      logic        mc;
      logic        mz;
      int          n;
      int          bad;
      logic [11:0] s_addr;
      logic [15:0] s_data;

      n_vec    = 0;
      n_err    = 0;
      wr_count = 0;
      rst_n    = 1'b0;
      mem_rdy  = 1'b1;

      vt[0]  = '{3'd0, 3'd1, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0};
      vt[1]  = '{3'd0, 3'd1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
      vt[2]  = '{3'd1, 3'd1, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0};
      vt[3]  = '{3'd1, 3'd1, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0};
      vt[4]  = '{3'd2, 3'd1, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0};
      vt[5]  = '{3'd3, 3'd1, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 1'b0};
      vt[6]  = '{3'd4, 3'd1, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b1};
      vt[7]  = '{3'd5, 3'd1, 16'h8001, 16'h0000, 16'h0002, 1'b1, 1'b0};
      vt[8]  = '{3'd6, 3'd1, 16'h8001, 16'h0000, 16'h4000, 1'b1, 1'b0};
      vt[9]  = '{3'd7, 3'd0, 16'h1111, 16'h00FF, 16'hFF00, 1'b0, 1'b0};
      vt[10] = '{3'd7, 3'd1, 16'h1111, 16'h1234, 16'h1234, 1'b0, 1'b0};
      vt[11] = '{3'd7, 3'd2, 16'h1111, 16'hFFFF, 16'h0000, 1'b1, 1'b1};
      vt[12] = '{3'd7, 3'd3, 16'h1111, 16'h0000, 16'hFFFF, 1'b1, 1'b0};
      vt[13] = '{3'd7, 3'd5, 16'h1111, 16'h5555, 16'h0000, 1'b0, 1'b1};

      for (int i = 0; i < 14; i++) begin
         run_alu(vt[i].f, vt[i].sel, vt[i].x, vt[i].y, vt[i].res, vt[i].cf, vt[i].zf);
      end

      for (int i = 0; i < 40; i++) begin
         rf = 3'($urandom_range(0, 7));
         rs = (rf == 3'd7) ? 3'($urandom_range(0, 7)) : 3'd1;
         rx = 16'($urandom);
         ry = 16'($urandom);
         if (i % 8 == 0) ry = rx;
         model(rf, rs, rx, ry, 1'b0, mr, mc, mz);
         run_alu(rf, rs, rx, ry, mr, mc, mz);
      end

      // LDI/LDI/SUB timing, JC taken, JZ not taken
      begin_prog();
      mem[0] = enc(4'h1, 3'd0, 3'd0, 3'd0, 3'd1);
      mem[1] = 16'h0005;
      mem[2] = enc(4'h1, 3'd0, 3'd0, 3'd0, 3'd2);
      mem[3] = 16'h0003;
      mem[4] = enc(4'h7, 3'd1, 3'd1, 3'd2, 3'd3);
      mem[5] = enc(4'h7, 3'd1, 3'd2, 3'd1, 3'd4);
      mem[6] = 16'h6000;
      mem[7] = 16'h0040;
      mem[12'h040] = 16'h4000;
      mem[12'h041] = 16'h0080;
      release_reset();
      n = 0;
      while (!(mem_req && mem_addr == 12'd4) && n < 20) begin
         cycle();
         n++;
      end
      chk("fetch3_cycles", n, 6);
      run_until_halt(60);
      chk("sub_r3", dut.regs[3], 16'h0002);
      chk("sub_r4", dut.regs[4], 16'hFFFE);
      chk("sub_c", dut.c, 1);
      chk("sub_z", dut.z, 0);
      chk("jc_jz_pc", dut.pc, 12'h043);

      // CALL / RET
      begin_prog();
      mem[0] = 16'h5000;
      mem[1] = 16'h0010;
      mem[12'h010] = 16'hA000;
      mem[12'h011] = 16'h0100;
      mem[12'h100] = 16'hB000;
      release_reset();
      n = 0;
      while (!(mem_req && mem_addr == 12'h100) && n < 30) begin
         cycle();
         n++;
      end
      chk("call_reached", mem_addr, 12'h100);
      chk("call_sp", dut.regs[7], 16'h0FFE);
      chk("call_ret_addr", mem[12'hFFE], 16'h0012);
      run_until_halt(30);
      chk("ret_pc", dut.pc, 12'h013);
      chk("ret_sp", dut.regs[7], 16'h0FFF);

      // ST with three wait states
      begin_prog();
      mem[0] = enc(4'h1, 3'd0, 3'd0, 3'd0, 3'd5);
      mem[1] = 16'hBEEF;
      mem[2] = enc(4'h1, 3'd0, 3'd0, 3'd0, 3'd6);
      mem[3] = 16'h0200;
      mem[4] = enc(4'h3, 3'd0, 3'd5, 3'd6, 3'd0);
      release_reset();
      n = 0;
      while (!(mem_req && mem_we) && n < 20) begin
         cycle();
         n++;
      end
      chk("st_addr", mem_addr, 12'h200);
      chk("st_wdata", mem_wdata, 16'hBEEF);
      s_addr  = mem_addr;
      s_data  = mem_wdata;
      mem_rdy = 1'b0;
      bad     = 0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         if (!(mem_req && mem_we && mem_addr == s_addr && mem_wdata == s_data)) bad++;
      end
      chk("st_stable", bad, 0);
      chk("st_no_early_write", wr_count, 0);
      mem_rdy = 1'b1;
      cycle();
      chk("st_advanced", mem_we, 0);
      run_until_halt(20);
      chk("st_write_count", wr_count, 1);
      chk("st_mem", mem[12'h200], 16'hBEEF);

      // PUSH then POP into R7, then HALT holds
      begin_prog();
      mem[0] = enc(4'h1, 3'd0, 3'd0, 3'd0, 3'd1);
      mem[1] = 16'h0ABC;
      mem[2] = enc(4'h8, 3'd0, 3'd1, 3'd0, 3'd0);
      mem[3] = enc(4'h9, 3'd0, 3'd0, 3'd0, 3'd7);
      release_reset();
      run_until_halt(30);
      chk("push_mem", mem[12'hFFE], 16'h0ABC);
      chk("pop_r7", dut.regs[7], 16'h0ABC);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         cycle();
         if (mem_req || !halted) bad++;
      end
      chk("halt_quiet", bad, 0);

      // Asynchronous reset during a stalled LD
      begin_prog();
      mem[0] = enc(4'h1, 3'd0, 3'd0, 3'd0, 3'd1);
      mem[1] = 16'h1234;
      mem[2] = enc(4'h1, 3'd0, 3'd0, 3'd0, 3'd3);
      mem[3] = 16'h0300;
      mem[4] = enc(4'h2, 3'd0, 3'd0, 3'd3, 3'd2);
      mem[12'h300] = 16'h5A5A;
      release_reset();
      n = 0;
      while (!(mem_req && mem_addr == 12'h300) && n < 20) begin
         cycle();
         n++;
      end
      chk("ld_reached", mem_addr, 12'h300);
      mem_rdy = 1'b0;
      cycle();
      cycle();
      chk("ld_stalled_req", mem_req, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_req_drop", mem_req, 0);
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      mem_rdy = 1'b1;
      #1;
      chk("rst_pc", dut.pc, 12'h000);
      chk("rst_r1", dut.regs[1], 16'h0000);
      chk("rst_r2", dut.regs[2], 16'h0000);
      chk("rst_r3", dut.regs[3], 16'h0000);
      chk("rst_r7", dut.regs[7], 16'h0FFF);
      chk("rst_req_again", mem_req, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
